// File: rtl/instr_register_mc_if.sv
// Issue/read bus of the multi-cycle instruction register.
// The master side drives requests and read pointers; the slave side returns stored entries and status.
interface instr_register_mc_if #(
  parameter int DEPTH = 32,
  parameter int OP_W  = 32
);
  localparam int AW    = $clog2(DEPTH);
  localparam int RES_W = 2 * OP_W;

  logic                    load_en;
  logic                    load_ready;
  logic [AW-1:0]           write_pointer;
  logic [3:0]              opcode;
  logic [OP_W-1:0]         operand_a;
  logic [OP_W-1:0]         operand_b;
  logic [AW-1:0]           read_pointer;
  logic [3:0]              rd_opcode;
  logic [OP_W-1:0]         rd_op_a;
  logic [OP_W-1:0]         rd_op_b;
  logic [RES_W-1:0]        rd_result;
  logic                    rd_done;
  logic                    busy;
  logic                    illegal_op;

  modport master (
    output load_en, write_pointer, opcode, operand_a, operand_b, read_pointer,
    input  load_ready, rd_opcode, rd_op_a, rd_op_b, rd_result, rd_done, busy, illegal_op
  );

  modport slave (
    input  load_en, write_pointer, opcode, operand_a, operand_b, read_pointer,
    output load_ready, rd_opcode, rd_op_a, rd_op_b, rd_result, rd_done, busy, illegal_op
  );
endinterface

// File: rtl/instr_register_mc.sv
// Instruction register with per-entry opcode, operands, result and done flag.
// ZERO..MULT resolve on the write edge; DIV/MOD/POW share one iterative engine.
module instr_register_mc #(
  parameter int DEPTH = 32,
  parameter int OP_W  = 32
) (
  input logic                 clk,
  input logic                 reset_n,
  instr_register_mc_if.slave  bus
);
  localparam int RES_W = 2 * OP_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(OP_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, WB} state_e;
  typedef enum logic [3:0] {
    OP_ZERO  = 4'd0, OP_PASSA = 4'd1, OP_PASSB = 4'd2, OP_ADD = 4'd3, OP_SUB = 4'd4,
    OP_MULT  = 4'd5, OP_DIV   = 4'd6, OP_MOD   = 4'd7, OP_POW = 4'd8
  } op_e;

  logic [3:0]       mem_opc  [DEPTH];
  logic [OP_W-1:0]  mem_a    [DEPTH];
  logic [OP_W-1:0]  mem_b    [DEPTH];
  logic [RES_W-1:0] mem_res  [DEPTH];
  logic             mem_done [DEPTH];

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       opc_l;
  logic [AW-1:0]    ptr_l;
  logic             sign_a, sign_b, a_zero, b_zero;
  logic [OP_W-1:0]  b_mag, q_sh, rem, b_sh;
  logic [RES_W-1:0] base, acc;
  logic             illegal_q;

  logic                    accept, is_multi, is_illegal;
  logic signed [RES_W-1:0] sa, sb, simple_res;
  logic [OP_W-1:0]         a_abs, b_abs;
  logic [OP_W:0]           rem_sh, rem_sub;
  logic                    ge;
  logic [RES_W-1:0]        sq, mul, q_ext, r_ext, wb_result;

  assign accept     = bus.load_en && (state == IDLE);
  assign is_multi   = (bus.opcode == OP_DIV) || (bus.opcode == OP_MOD) || (bus.opcode == OP_POW);
  assign is_illegal = bus.opcode > 4'(OP_POW);

  assign sa    = {{OP_W{bus.operand_a[OP_W-1]}}, bus.operand_a};
  assign sb    = {{OP_W{bus.operand_b[OP_W-1]}}, bus.operand_b};
  assign a_abs = bus.operand_a[OP_W-1] ? (~bus.operand_a + 1'b1) : bus.operand_a;
  assign b_abs = bus.operand_b[OP_W-1] ? (~bus.operand_b + 1'b1) : bus.operand_b;

  always_comb begin
    simple_res = '0;
    case (bus.opcode)
      OP_PASSA: simple_res = sa;
      OP_PASSB: simple_res = sb;
      OP_ADD:   simple_res = sa + sb;
      OP_SUB:   simple_res = sa - sb;
      OP_MULT:  simple_res = sa * sb;
      default:  simple_res = '0;
    endcase
  end

  // Restoring divide and MSB-first square-and-multiply advance together; opc_l picks the result at WB.
  assign rem_sh  = {rem, q_sh[OP_W-1]};
  assign rem_sub = rem_sh - {1'b0, b_mag};
  assign ge      = rem_sh >= {1'b0, b_mag};
  assign sq      = acc * acc;
  assign mul     = sq * base;
  assign q_ext   = {{OP_W{1'b0}}, q_sh};
  assign r_ext   = {{OP_W{1'b0}}, rem};

  always_comb begin
    wb_result = '0;
    case (opc_l)
      OP_DIV:  wb_result = b_zero ? '0 : ((sign_a ^ sign_b) ? -q_ext : q_ext);
      OP_MOD:  wb_result = b_zero ? '0 : (sign_a ? -r_ext : r_ext);
      OP_POW:  wb_result = (a_zero || sign_b) ? '0 : acc;
      default: wb_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      opc_l     <= '0;
      ptr_l     <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      a_zero    <= 1'b0;
      b_zero    <= 1'b0;
      b_mag     <= '0;
      q_sh      <= '0;
      rem       <= '0;
      b_sh      <= '0;
      base      <= '0;
      acc       <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && is_illegal;
      case (state)
        IDLE: if (accept && is_multi) begin
          state  <= CALC;
          cnt    <= '0;
          opc_l  <= bus.opcode;
          ptr_l  <= bus.write_pointer;
          sign_a <= bus.operand_a[OP_W-1];
          sign_b <= bus.operand_b[OP_W-1];
          a_zero <= (bus.operand_a == '0);
          b_zero <= (bus.operand_b == '0);
          b_mag  <= b_abs;
          q_sh   <= a_abs;
          rem    <= '0;
          b_sh   <= bus.operand_b;
          base   <= sa;
          acc    <= RES_W'(1);
        end
        CALC: begin
          q_sh <= {q_sh[OP_W-2:0], ge};
          rem  <= ge ? rem_sub[OP_W-1:0] : rem_sh[OP_W-1:0];
          b_sh <= b_sh << 1;
          acc  <= b_sh[OP_W-1] ? mul : sq;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(OP_W - 1)) state <= WB;
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_opc[AW'(i)]  <= '0;
        mem_a[AW'(i)]    <= '0;
        mem_b[AW'(i)]    <= '0;
        mem_res[AW'(i)]  <= '0;
        mem_done[AW'(i)] <= 1'b0;
      end
    end else if (accept) begin
      mem_opc[bus.write_pointer]  <= bus.opcode;
      mem_a[bus.write_pointer]    <= bus.operand_a;
      mem_b[bus.write_pointer]    <= bus.operand_b;
      mem_res[bus.write_pointer]  <= is_multi ? '0 : simple_res;
      mem_done[bus.write_pointer] <= !is_multi;
    end else if (state == WB) begin
      mem_res[ptr_l]  <= wb_result;
      mem_done[ptr_l] <= 1'b1;
    end
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.illegal_op = illegal_q;
  assign bus.rd_opcode  = mem_opc[bus.read_pointer];
  assign bus.rd_op_a    = mem_a[bus.read_pointer];
  assign bus.rd_op_b    = mem_b[bus.read_pointer];
  assign bus.rd_result  = mem_res[bus.read_pointer];
  assign bus.rd_done    = mem_done[bus.read_pointer];
endmodule

// File: tb/tb_instr_register_mc.sv
// Directed bench for instr_register_mc: simple ops, multi-cycle latency/backpressure,
// corner cases, mid-operation reset, illegal opcodes and held requests.
module tb_instr_register_mc;
  localparam int DEPTH = 32;
  localparam int OP_W  = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  instr_register_mc_if #(.DEPTH(DEPTH), .OP_W(OP_W)) bus ();

  instr_register_mc #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input int a, input int b, input int unsigned ptr);
    bus.opcode        = op;
    bus.operand_a     = a;
    bus.operand_b     = b;
    bus.write_pointer = 5'(ptr);
    bus.read_pointer  = 5'(ptr);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: busy=%b illegal_op=%b required 0 0", bus.busy, bus.illegal_op);
    end
    reset_n = 1'b1;
    #1;
    for (int p = 0; p < DEPTH; p++) begin
      bus.read_pointer = 5'(p);
      #1;
      checks++;
      if (bus.rd_opcode !== 4'd0 || bus.rd_result !== 64'd0 || bus.rd_done !== 1'b0 ||
          bus.load_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_entry%0d: opc=%0d res=%0d done=%b ready=%b required 0 0 0 1",
                 p, bus.rd_opcode, bus.rd_result, bus.rd_done, bus.load_ready);
      end
    end
  endtask

  task automatic test_simple_back_to_back;
    drive(4'd3, -7, 5, 3);
    bus.load_en = 1'b1;
    #1;
    checks++;
    if (bus.rd_done !== 1'b0 || bus.rd_result !== 64'd0) begin
      failures++;
      $display("FAIL pre_edge_read: done=%b res=%0d required 0 0", bus.rd_done, bus.rd_result);
    end
    tick;
    checks++;
    if (bus.load_ready !== 1'b1 || bus.rd_done !== 1'b1 || bus.rd_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      failures++;
      $display("FAIL add_ptr3: ready=%b done=%b res=%0d required 1 1 -2",
               bus.load_ready, bus.rd_done, $signed(bus.rd_result));
    end
    drive(4'd5, -3, 4, 4);
    tick;
    bus.load_en = 1'b0;
    checks++;
    if (bus.load_ready !== 1'b1 || bus.rd_done !== 1'b1 || bus.rd_result !== 64'hFFFF_FFFF_FFFF_FFF4) begin
      failures++;
      $display("FAIL mult_ptr4: ready=%b done=%b res=%0d required 1 1 -12",
               bus.load_ready, bus.rd_done, $signed(bus.rd_result));
    end
    bus.read_pointer = 5'd3;
    #1;
    checks++;
    if (bus.rd_result !== 64'hFFFF_FFFF_FFFF_FFFE || bus.rd_opcode !== 4'd3) begin
      failures++;
      $display("FAIL add_ptr3_kept: res=%0d opc=%0d required -2 3", $signed(bus.rd_result), bus.rd_opcode);
    end
  endtask

  task automatic test_simple_ops;
    logic [3:0]  ops [5] = '{4'd4, 4'd1, 4'd2, 4'd0, 4'd5};
    int          as  [5] = '{5, -100, 1, 99, int'(32'h8000_0000)};
    int          bs  [5] = '{9, 3, 77, 42, int'(32'h8000_0000)};
    longint      exs [5] = '{-4, -100, 77, 0, 64'h4000_0000_0000_0000};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], as[i], bs[i], 16 + i);
      bus.load_en = 1'b1;
      tick;
      bus.load_en = 1'b0;
      checks++;
      if (bus.rd_done !== 1'b1 || bus.rd_result !== exs[i] || bus.rd_op_b !== bs[i]) begin
        failures++;
        $display("FAIL simple_op%0d: done=%b res=%0d required 1 %0d",
                 ops[i], bus.rd_done, $signed(bus.rd_result), exs[i]);
      end
    end
  endtask

  task automatic run_multi(input logic [3:0] op, input int a, input int b,
                           input int unsigned ptr, input longint ex, input string name);
    bit bad = 1'b0;
    drive(op, a, b, ptr);
    bus.load_en = 1'b1;
    tick;
    bus.load_en = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.load_ready !== 1'b0 || bus.rd_done !== 1'b0 ||
        bus.rd_op_a !== a || bus.rd_opcode !== op) begin
      failures++;
      $display("FAIL %s_accept: busy=%b ready=%b done=%b opc=%0d required 1 0 0 %0d",
               name, bus.busy, bus.load_ready, bus.rd_done, bus.rd_opcode, op);
    end
    for (int i = 1; i <= OP_W; i++) begin
      tick;
      if (bus.busy !== 1'b1 || bus.load_ready !== 1'b0 || bus.rd_done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s_latency: finished before edge E0+%0d, required busy throughout", name, OP_W + 1);
    end
    tick;
    checks++;
    if (bus.rd_done !== 1'b1 || bus.rd_result !== ex || bus.busy !== 1'b0 || bus.load_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_result: done=%b busy=%b res=%0d required 1 0 %0d",
               name, bus.rd_done, bus.busy, $signed(bus.rd_result), ex);
    end
  endtask

  task automatic test_multi_cycle;
    run_multi(4'd6, -15, 4, 7, -3, "div_neg");
    run_multi(4'd7, -15, 4, 8, -3, "mod_neg");
    run_multi(4'd6, 15, -4, 9, -3, "div_negb");
    run_multi(4'd7, 15, -4, 10, 3, "mod_negb");
    run_multi(4'd6, int'(32'h8000_0000), -1, 11, 64'h0000_0000_8000_0000, "div_min");
    run_multi(4'd8, 3, 5, 12, 243, "pow_3_5");
    run_multi(4'd8, -2, 3, 13, -8, "pow_m2_3");
    run_multi(4'd8, 2, 40, 14, 64'h0000_0100_0000_0000, "pow_2_40");
    run_multi(4'd8, 0, 0, 15, 0, "pow_0_0");
    run_multi(4'd8, 7, 0, 16, 1, "pow_7_0");
    run_multi(4'd8, 2, -1, 17, 0, "pow_neg_exp");
    run_multi(4'd6, 9, 0, 18, 0, "div_zero");
    run_multi(4'd7, 9, 0, 19, 0, "mod_zero");
  endtask

  task automatic test_reset_mid_div;
    bit bad = 1'b0;
    drive(4'd6, 100, 7, 9);
    bus.load_en = 1'b1;
    tick;
    bus.load_en = 1'b0;
    repeat (9) tick;
    @(posedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.rd_opcode !== 4'd0 || bus.rd_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b opc=%0d done=%b required 0 0 0", bus.busy, bus.rd_opcode, bus.rd_done);
    end
    tick;
    tick;
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.busy !== 1'b0 || bus.rd_done !== 1'b0 || bus.rd_result !== 64'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL mid_reset_no_wb: entry 9 written after reset, required stays cleared");
    end
  endtask

  task automatic test_hold_request;
    bit bad = 1'b0;
    drive(4'd6, 20, 3, 11);
    bus.load_en = 1'b1;
    tick;
    drive(4'd3, 1, 2, 12);
    for (int i = 1; i <= OP_W; i++) begin
      tick;
      if (bus.load_ready !== 1'b0 || bus.rd_done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL hold_blocked: held request accepted while busy, required blocked");
    end
    tick;
    checks++;
    if (bus.load_ready !== 1'b1 || bus.rd_done !== 1'b0) begin
      failures++;
      $display("FAIL hold_ready: ready=%b done12=%b required 1 0", bus.load_ready, bus.rd_done);
    end
    bus.read_pointer = 5'd11;
    #1;
    checks++;
    if (bus.rd_done !== 1'b1 || bus.rd_result !== 64'd6) begin
      failures++;
      $display("FAIL hold_div: done=%b res=%0d required 1 6", bus.rd_done, $signed(bus.rd_result));
    end
    bus.read_pointer = 5'd12;
    tick;
    bus.load_en = 1'b0;
    checks++;
    if (bus.rd_done !== 1'b1 || bus.rd_result !== 64'd3 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_add: done=%b res=%0d busy=%b required 1 3 0",
               bus.rd_done, $signed(bus.rd_result), bus.busy);
    end
  endtask

  task automatic test_illegal;
    drive(4'd12, 5, 6, 20);
    checks++;
    if (bus.illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL illegal_idle: illegal_op=%b required 0", bus.illegal_op);
    end
    bus.load_en = 1'b1;
    tick;
    bus.load_en = 1'b0;
    checks++;
    if (bus.illegal_op !== 1'b1 || bus.rd_opcode !== 4'd12 || bus.rd_result !== 64'd0 ||
        bus.rd_done !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL illegal_accept: pulse=%b opc=%0d res=%0d done=%b required 1 12 0 1",
               bus.illegal_op, bus.rd_opcode, bus.rd_result, bus.rd_done);
    end
    tick;
    checks++;
    if (bus.illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL illegal_pulse_width: illegal_op=%b required 0", bus.illegal_op);
    end
  endtask

  initial begin
    bus.load_en       = 1'b0;
    bus.write_pointer = '0;
    bus.opcode        = '0;
    bus.operand_a     = '0;
    bus.operand_b     = '0;
    bus.read_pointer  = '0;
    test_reset;
    test_simple_back_to_back;
    test_simple_ops;
    test_multi_cycle;
    test_reset_mid_div;
    test_hold_request;
    test_illegal;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_register_mc.md
Name: instr_register_mc

Overview:
- Parametrised successor of the instruction register: stores opcode, operands and computed result per entry, with configurable depth and operand width.
- Simple ops (ZERO..MULT) are computed on the write cycle. DIV, MOD and POW run on a shared multi-cycle engine with backpressure.
- A per-entry done flag lets the bench or consumer tell completed results from pending ones.
- Sits between the instruction-issue testbench/driver and the result-checking logic.

Parameters:
- DEPTH, 32, number of entries; power of 2, >= 2.
- OP_W, 32, operand width; operands are signed two's complement.
- RES_W, 2*OP_W, result width; signed.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  reset; asynchronous, active-low.
- load_en  input  1  write request valid.
- load_ready  output  1  engine can accept a request this cycle.
- write_pointer  input  AW  destination entry.
- opcode  input  4  0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD, 8 POW; codes 9-15 are illegal.
- operand_a  input  OP_W  signed operand A.
- operand_b  input  OP_W  signed operand B.
- read_pointer  input  AW  read entry; combinational read.
- rd_opcode  output  4  stored opcode at read_pointer.
- rd_op_a  output  OP_W  stored operand A.
- rd_op_b  output  OP_W  stored operand B.
- rd_result  output  RES_W  stored result.
- rd_done  output  1  result at read_pointer is valid.
- busy  output  1  multi-cycle engine is occupied.
- illegal_op  output  1  one-cycle pulse when an illegal opcode is accepted.

Behaviour:
- Reset (asynchronous, mid-operation included):
  - All entries become opc=0, ops=0, result=0, done=0.
  - FSM goes to IDLE; busy=0, illegal_op=0, load_ready=1 once reset is released.
  - Any in-flight DIV/MOD/POW is aborted and nothing is written back.
- Accept rule: a request is accepted on a posedge when load_en && load_ready. load_ready = (state==IDLE).
- Simple ops, on the accept edge:
  - Write opc/op_a/op_b to the entry.
  - Result is sign-extended to RES_W and truncated mod 2^RES_W: ZERO=0, PASSA=a, PASSB=b, ADD=a+b, SUB=a-b, MULT=a*b (full signed product).
  - done=1 on the same edge.
  - Back-to-back accepts are allowed every cycle.
- Multi-cycle ops (DIV/MOD/POW), on the accept edge:
  - Entry gets opc/ops, done=0.
  - Operands, opcode and pointer are latched; state goes IDLE->CALC; iteration counter=0.
- CALC state:
  - One iteration per edge, OP_W iterations total, then state goes to WB.
  - DIV/MOD: restoring divide on magnitudes. Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - POW: square-and-multiply over the bits of b, MSB first, modulo 2^RES_W.
- WB state: on the next edge, write result to the latched entry, set done=1, state goes to IDLE.
- Latency: result visible on rd_result/rd_done immediately after edge E0+OP_W+1, where E0 is the accept edge. load_ready rises in the same cycle.
- busy = (state!=IDLE).
- Special cases:
  - DIV with b==0 gives 0; MOD with b==0 gives 0.
  - POW with a==0 gives 0 (including b==0).
  - POW with b<0 gives 0.
  - POW with b==0 and a!=0 gives 1.
  - The special cases still take the full latency.
- Illegal opcode: accepted as a simple op; entry stores the opcode, result=0, done=1; illegal_op pulses for one cycle.
- Collisions:
  - If an in-flight entry is overwritten, this cannot happen in the same cycle because load_ready=0 during CALC/WB.
  - A read of an in-flight entry returns the new ops with done=0.
  - A read of the entry being written on the same edge returns the old contents before the edge and the new contents after it.
- Pointers: no wrap logic; pointers index modulo DEPTH by construction.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles, then sweep read_pointer 0..31 -> every entry reads opc 0, result 0, rd_done 0; load_ready=1.
- Simple ops back-to-back: ADD a=-7 b=5 @ptr3, then MULT a=-3 b=4 @ptr4 on consecutive cycles -> ptr3 result -2 with done=1; ptr4 result -12 with done=1; load_ready stays high throughout.
- DIV latency/backpressure: DIV a=-15 b=4 @ptr7 -> busy for 33 cycles, load_ready low, rd_done(7)=0. After edge E0+33, result -3 with done=1. MOD of the same operands -> -3.
- POW and corners:
  - POW a=3 b=5 -> 243.
  - POW a=0 b=0 -> 0.
  - POW a=2 b=-1 -> 0.
  - DIV/MOD with b=0 -> 0.
  - MULT a=-2^31 b=-2^31 -> 2^62.
- Reset mid-DIV: assert reset_n at E0+10 -> entry is cleared, busy=0, no later writeback.
- Illegal/hold: opcode 12 -> illegal_op pulses one cycle, result 0, done=1. load_en held high during DIV -> the request is accepted on the first cycle load_ready=1, then completes normally.
